// File: rtl/fifo_pkg.sv
// Shared defaults for the register-file FIFO and its pointer-width helper.
// Latency: n/a (constants and an elaboration-time function only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_AFULL = 6;

    // Address width for a DEPTH-entry array; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH flop array with one synchronous write port and one async read port.
// Latency: write lands at the clock edge; read data is combinational from raddr.
// Backpressure: none; the controller owns all flow control. Contents are not reset.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Capture the write word into the addressed entry; no reset on storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a flop-based FIFO with first-word fall-through output.
// Latency: a word pushed at edge N appears on rd_data with rd_valid from cycle N+1.
// Backpressure: wr_ready drops when full or in reset; rd_valid drops when empty.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AFULL = DEF_AFULL,
    localparam int AW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits coincide.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;

    logic        push;
    logic        pop;
    logic        full_w;
    logic        empty_w;
    logic [AW:0] count_w;

    // Flags come only from registered pointers, keeping wr_valid/rd_ready
    // off every combinational output path.
    assign empty_w = (wptr_q == rptr_q);
    assign full_w  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_w = wptr_q - rptr_q;

    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = count_w;
    assign almost_full = (count_w >= AFULL_C);

    // rst gates wr_ready so a producer never sees acceptance during reset;
    // flush deliberately does not, it only discards state at the edge.
    assign wr_ready = ~full_w & ~rst;
    assign rd_valid = ~empty_w;

    assign push = wr_valid & wr_ready;
    assign pop  = rd_valid & rd_ready;

    // Next-state pointers: flush clears both and discards any handshake in the same cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage: a word accepted alongside a flush is dropped, so the write is suppressed too.
    fifo_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized and directed stimulus against a queue-based FIFO reference model.
// Latency: checks every cycle at the falling edge, model updates at the rising edge.
// Backpressure: model decides acceptance from its own occupancy, never from the DUT.
module tb_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [3:0] count;

    fifo_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AFULL (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    bit         model_ok = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive, compare against model at negedge, then advance model at posedge.
    task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                        input logic fl, input logic rs);
        int  occ;
        bit  do_push;
        bit  do_pop;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        rst      = rs;
        @(negedge clk);
        occ = q.size();
        if (model_ok || rs) begin
            check_eq("wr_ready", {31'd0, wr_ready}, {31'd0, (!rs && occ < DEPTH)});
        end
        if (model_ok) begin
            check_eq("count",       {28'd0, count},       32'(occ));
            check_eq("empty",       {31'd0, empty},       {31'd0, (occ == 0)});
            check_eq("full",        {31'd0, full},        {31'd0, (occ == DEPTH)});
            check_eq("almost_full", {31'd0, almost_full}, {31'd0, (occ >= AFULL)});
            check_eq("rd_valid",    {31'd0, rd_valid},    {31'd0, (occ != 0)});
            if (occ != 0) begin
                check_eq("rd_data", {24'd0, rd_data}, {24'd0, q[0]});
            end
        end
        do_push = wv && !rs && (occ < DEPTH);
        do_pop  = rr && (occ > 0);
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
            model_ok = 1;
        end else if (model_ok) begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(wd);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_to(input int n);
        while (q.size() < n) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain_to(input int n);
        while (q.size() > n) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        @(posedge clk);
        #1;

        // Reset held three cycles, then released.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle();

        // Fill with 0x11..0x88, then one refused write of 0x99.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        idle();

        // Drain in order, then confirm empty.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();

        // Concurrent push/pop at occupancy 4 across pointer wrap.
        fill_to(4);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        idle();

        // Both handshakes at full: only the pop, then the held word is accepted.
        fill_to(DEPTH);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle();

        // Both handshakes at empty: only the push.
        drain_to(0);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        idle();

        // Flush at occupancy 5 with a write offered.
        fill_to(5);
        step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
        idle();

        // Reset at occupancy 5 with a write offered.
        fill_to(5);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 59) == 0),
                 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
